regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter XLEN, default 32: register width in bits.
REQ-002 SHALL have parameter NREG, default 32: register count, a power of two and at least 4; AW = log2(NREG).
REQ-003 SHALL have parameter NRD, default 2: number of independent read ports.
REQ-004 clock  input  1  clock; all state updates on its rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 rd_addr  input  NRD*AW  read addresses; port k occupies bits [k*AW +: AW].
REQ-007 rd_data  output  NRD*XLEN  read data; port k occupies bits [k*XLEN +: XLEN].
REQ-008 rd_busy  output  NRD  port k register has a pending write.
REQ-009 wr_en  input  1  write-back strobe.
REQ-010 wr_addr  input  AW  write-back register.
REQ-011 wr_data  input  XLEN  write-back data.
REQ-012 iss_en  input  1  issue strobe; marks iss_addr pending.
REQ-013 iss_addr  input  AW  destination register of the issued instruction.
REQ-014 ready  output  1  initialisation complete; accesses accepted.

Function
REQ-015 SHALL run a two-state sequencer, INIT and RUN; ready = 1 exactly in RUN.
REQ-016 INIT: each rising edge writes reg[ptr] = ptr, zero-extended to XLEN, then increments ptr; the edge that writes reg[NREG-1] moves the sequencer to RUN.
REQ-017 ready SHALL rise after exactly NREG rising edges following reset deassertion.
REQ-018 In INIT, wr_en and iss_en SHALL be ignored, rd_data SHALL be all zeros and rd_busy all zeros.
REQ-019 Reads SHALL be combinational, with zero latency, and independent per port.
REQ-020 Read priority in RUN: address 0 -> 0; else wr_en and wr_addr == rd_addr -> wr_data (write bypass); else the stored value.
REQ-021 Write in RUN: wr_en with wr_addr != 0 updates reg[wr_addr] at the rising edge; writes to address 0 are discarded.
REQ-022 Register 0 SHALL always read 0 and SHALL never be busy.
REQ-023 Scoreboard, RUN only: iss_en with iss_addr != 0 sets busy[iss_addr]; wr_en clears busy[wr_addr].
REQ-024 If iss_en and wr_en target the same address in one cycle, the set SHALL win: the register stays busy and the data is still written.
REQ-025 Issue to an already-busy register SHALL leave it busy, with no error and no count.
REQ-026 Write to a non-busy register SHALL be legal and SHALL leave busy unchanged.
REQ-027 rd_busy[k] = busy[rd_addr_k] AND NOT (wr_en AND wr_addr == rd_addr_k), so a bypassed read is never reported busy.
REQ-028 Ports reading the same address in one cycle SHALL return identical data and busy.

Reset
REQ-029 Reset assertion SHALL immediately force INIT, ptr = 0, ready = 0 and all busy bits = 0, independent of clock.
REQ-030 Register contents are not cleared by reset itself; they are rewritten by the INIT sweep.
REQ-031 Reset asserted in INIT or RUN SHALL abort the current sweep or operation and restart the sweep from ptr = 0 after deassertion.

Structure
REQ-032 Shared package regfile_pkg SHALL hold the XLEN and NREG defaults and the sequencer state enumeration (INIT, RUN).
REQ-033 Sub-module regfile_init_seq SHALL contain the INIT/RUN FSM and ptr counter, and SHALL output ready, init_we, init_addr and init_data.
REQ-034 Storage SHALL be a flat array of NREG x XLEN with no reset on the array.

Verification
REQ-035 Reset, release, count edges -> ready = 1 after exactly 32 edges; reads of x5 and x31 return 5 and 31.
REQ-036 In RUN, wr_en = 1, wr_addr = 7, wr_data = 0xDEADBEEF, rd_addr0 = 7 in the same cycle -> rd_data0 = 0xDEADBEEF combinationally; next cycle, with wr_en = 0, still 0xDEADBEEF.
REQ-037 Write 0x1234 to x0, then read x0 on both ports -> 0 and rd_busy = 0.
REQ-038 Issue x9 -> rd_busy = 1 next cycle; then iss_en and wr_en to x9 in the same cycle -> busy remains 1; then wr_en alone to x9 with data 0x55 -> busy clears and x9 reads 0x55.
REQ-039 Assert reset 10 cycles into INIT (NREG = 32) -> ready stays 0 and busy is 0; after release, ready rises 32 edges later.
REQ-040 Set NREG = 8, NRD = 3 -> ready after 8 edges; three simultaneous reads of x3 each return 3.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults and sequencer state encoding for the scoreboarded register file.
package regfile_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int NREG_DEFAULT = 32;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

endpackage

// File: rtl/regfile_init_seq.sv
// Power-up sequencer: sweeps every register with its own index, then enters RUN.
module regfile_init_seq
    import regfile_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int NREG = NREG_DEFAULT
) (
    input  logic                     clock,
    input  logic                     reset,
    output logic                     ready,
    output logic                     init_we,
    output logic [$clog2(NREG)-1:0]  init_addr,
    output logic [XLEN-1:0]          init_data
);

    localparam int AW = $clog2(NREG);

    seq_state_t      state;
    logic [AW-1:0]   ptr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= INIT;
            ptr   <= '0;
            ready <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    ptr <= ptr + 1'b1;
                    // The edge that writes the last register is the one that enters RUN.
                    if (ptr == AW'(NREG - 1)) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    state <= RUN;
                end
                default: begin
                    state <= INIT;
                    ptr   <= '0;
                    ready <= 1'b0;
                end
            endcase
        end
    end

    assign init_we   = (state == INIT);
    assign init_addr = ptr;
    assign init_data = XLEN'(ptr);

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with write bypass and a pending-write scoreboard.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int NREG = NREG_DEFAULT,
    parameter int NRD  = 2
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NRD*$clog2(NREG)-1:0]  rd_addr,
    output logic [NRD*XLEN-1:0]          rd_data,
    output logic [NRD-1:0]               rd_busy,
    input  logic                         wr_en,
    input  logic [$clog2(NREG)-1:0]      wr_addr,
    input  logic [XLEN-1:0]              wr_data,
    input  logic                         iss_en,
    input  logic [$clog2(NREG)-1:0]      iss_addr,
    output logic                         ready
);

    localparam int AW = $clog2(NREG);

    logic [XLEN-1:0]  mem [NREG];
    logic [NREG-1:0]  busy;
    logic             init_we;
    logic [AW-1:0]    init_addr;
    logic [XLEN-1:0]  init_data;

    regfile_init_seq #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_init_seq (
        .clock     (clock),
        .reset     (reset),
        .ready     (ready),
        .init_we   (init_we),
        .init_addr (init_addr),
        .init_data (init_data)
    );

    // Storage is never reset; the INIT sweep is what gives it defined contents.
    always_ff @(posedge clock) begin
        if (init_we) begin
            mem[init_addr] <= init_data;
        end else if (ready && wr_en && (wr_addr != '0)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Issue is applied after write-back so a same-cycle set wins over the clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else if (ready) begin
            if (wr_en) begin
                busy[wr_addr] <= 1'b0;
            end
            if (iss_en && (iss_addr != '0)) begin
                busy[iss_addr] <= 1'b1;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int k = 0; k < NRD; k++) begin
            if (ready && (rd_addr[k*AW +: AW] != '0)) begin
                if (wr_en && (wr_addr == rd_addr[k*AW +: AW])) begin
                    rd_data[k*XLEN +: XLEN] = wr_data;
                end else begin
                    rd_data[k*XLEN +: XLEN] = mem[rd_addr[k*AW +: AW]];
                    rd_busy[k]              = busy[rd_addr[k*AW +: AW]];
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: default configuration plus an 8-register, 3-port instance.
module tb_regfile_sb;

    logic        clock;
    logic        reset;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic        ready;

    logic        reset_b;
    logic [8:0]  rd_addr_b;
    logic [95:0] rd_data_b;
    logic [2:0]  rd_busy_b;
    logic        ready_b;

    int tests;
    int fails;

    regfile_sb dut (
        .clock    (clock),
        .reset    (reset),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .ready    (ready)
    );

    regfile_sb #(.XLEN(32), .NREG(8), .NRD(3)) dut_small (
        .clock    (clock),
        .reset    (reset_b),
        .rd_addr  (rd_addr_b),
        .rd_data  (rd_data_b),
        .rd_busy  (rd_busy_b),
        .wr_en    (1'b0),
        .wr_addr  (3'd0),
        .wr_data  (32'd0),
        .iss_en   (1'b0),
        .iss_addr (3'd0),
        .ready    (ready_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        iss_en   = 1'b0;
        iss_addr = '0;
    endtask

    task automatic test_reset();
        int n;
        reset   = 1'b1;
        rd_addr = {5'd31, 5'd5};
        idle_inputs();
        #12;
        tests++;
        if (ready !== 1'b0 || rd_data !== 64'd0 || rd_busy !== 2'b00) begin
            fails++;
            $display("FAIL reset_state: ready=%b rd_data=%h rd_busy=%b, expected 0/0/0", ready, rd_data, rd_busy);
        end
        // Accesses during INIT must be ignored.
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hFFFF_FFFF;
        iss_en = 1'b1; iss_addr = 5'd31;
        @(negedge clock);
        reset = 1'b0;
        n = 0;
        tick();
        n++;
        tests++;
        if (rd_data !== 64'd0 || rd_busy !== 2'b00) begin
            fails++;
            $display("FAIL init_reads_zero: rd_data=%h rd_busy=%b, expected 0/00", rd_data, rd_busy);
        end
        while (ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        idle_inputs();
        #1;
        tests++;
        if (n != 32) begin
            fails++;
            $display("FAIL ready_edges: got %0d edges, expected 32", n);
        end
        tests++;
        if (rd_data !== {32'd31, 32'd5} || rd_busy !== 2'b00) begin
            fails++;
            $display("FAIL init_values: rd_data=%h rd_busy=%b, expected %h/00", rd_data, rd_busy, {32'd31, 32'd5});
        end
    endtask

    task automatic test_bypass();
        rd_addr = {5'd8, 5'd7};
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hDEAD_BEEF;
        #1;
        tests++;
        if (rd_data !== {32'd8, 32'hDEAD_BEEF} || rd_busy !== 2'b00) begin
            fails++;
            $display("FAIL bypass: rd_data=%h rd_busy=%b, expected %h/00", rd_data, rd_busy, {32'd8, 32'hDEAD_BEEF});
        end
        tick();
        idle_inputs();
        #1;
        tests++;
        if (rd_data[31:0] !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL write_stored: rd_data0=%h, expected deadbeef", rd_data[31:0]);
        end
    endtask

    task automatic test_x0();
        rd_addr = {5'd0, 5'd0};
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h0000_1234;
        iss_en = 1'b1; iss_addr = 5'd0;
        #1;
        tests++;
        if (rd_data !== 64'd0) begin
            fails++;
            $display("FAIL x0_no_bypass: rd_data=%h, expected 0", rd_data);
        end
        tick();
        idle_inputs();
        #1;
        tests++;
        if (rd_data !== 64'd0 || rd_busy !== 2'b00) begin
            fails++;
            $display("FAIL x0_read: rd_data=%h rd_busy=%b, expected 0/00", rd_data, rd_busy);
        end
    endtask

    task automatic test_scoreboard();
        rd_addr = {5'd13, 5'd9};
        iss_en = 1'b1; iss_addr = 5'd9;
        tick();
        idle_inputs();
        #1;
        tests++;
        if (rd_busy !== 2'b01 || rd_data[31:0] !== 32'd9) begin
            fails++;
            $display("FAIL issue_busy: rd_busy=%b data0=%h, expected 01/9", rd_busy, rd_data[31:0]);
        end
        iss_en = 1'b1; iss_addr = 5'd9;
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h0000_00AA;
        #1;
        tests++;
        if (rd_busy !== 2'b00 || rd_data[31:0] !== 32'hAA) begin
            fails++;
            $display("FAIL bypass_not_busy: rd_busy=%b data0=%h, expected 00/aa", rd_busy, rd_data[31:0]);
        end
        tick();
        idle_inputs();
        #1;
        tests++;
        if (rd_busy !== 2'b01 || rd_data[31:0] !== 32'hAA) begin
            fails++;
            $display("FAIL set_wins: rd_busy=%b data0=%h, expected 01/aa", rd_busy, rd_data[31:0]);
        end
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h0000_0055;
        tick();
        idle_inputs();
        #1;
        tests++;
        if (rd_busy !== 2'b00 || rd_data[31:0] !== 32'h55) begin
            fails++;
            $display("FAIL writeback_clears: rd_busy=%b data0=%h, expected 00/55", rd_busy, rd_data[31:0]);
        end
        // Re-issue of a busy register and a write to an idle register.
        rd_addr = {5'd13, 5'd12};
        iss_en = 1'b1; iss_addr = 5'd12;
        tick();
        tick();
        idle_inputs();
        wr_en = 1'b1; wr_addr = 5'd13; wr_data = 32'h0000_0777;
        tick();
        idle_inputs();
        #1;
        tests++;
        if (rd_busy !== 2'b01 || rd_data !== {32'h777, 32'd12}) begin
            fails++;
            $display("FAIL reissue_idle_write: rd_busy=%b rd_data=%h, expected 01/%h", rd_busy, rd_data, {32'h777, 32'd12});
        end
    endtask

    task automatic test_reset_mid_init();
        int n;
        // Asynchronous reset in RUN drops busy and ready without a clock edge.
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        tests++;
        if (ready !== 1'b0 || rd_busy !== 2'b00) begin
            fails++;
            $display("FAIL async_reset_run: ready=%b rd_busy=%b, expected 0/00", ready, rd_busy);
        end
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        #2;
        reset = 1'b1;
        #1;
        tests++;
        if (ready !== 1'b0 || rd_busy !== 2'b00) begin
            fails++;
            $display("FAIL reset_mid_init: ready=%b rd_busy=%b, expected 0/00", ready, rd_busy);
        end
        rd_addr = {5'd13, 5'd7};
        @(negedge clock);
        reset = 1'b0;
        n = 0;
        while (ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        tests++;
        if (n != 32) begin
            fails++;
            $display("FAIL restart_edges: got %0d edges, expected 32", n);
        end
        tests++;
        if (rd_data !== {32'd13, 32'd7}) begin
            fails++;
            $display("FAIL sweep_rewrites: rd_data=%h, expected %h", rd_data, {32'd13, 32'd7});
        end
    endtask

    task automatic test_small();
        int n;
        reset_b   = 1'b1;
        rd_addr_b = {3'd3, 3'd3, 3'd3};
        @(negedge clock);
        reset_b = 1'b0;
        n = 0;
        while (ready_b !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        tests++;
        if (n != 8) begin
            fails++;
            $display("FAIL small_ready_edges: got %0d edges, expected 8", n);
        end
        tests++;
        if (rd_data_b !== {32'd3, 32'd3, 32'd3} || rd_busy_b !== 3'b000) begin
            fails++;
            $display("FAIL small_three_ports: rd_data=%h rd_busy=%b, expected %h/000", rd_data_b, rd_busy_b, {32'd3, 32'd3, 32'd3});
        end
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        reset_b   = 1'b1;
        rd_addr_b = '0;
        test_reset();
        test_bypass();
        test_x0();
        test_scoreboard();
        test_reset_mid_init();
        test_small();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
